fetch_stage: RTL

//  Instruction-fetch front end of the CPU. It owns the PC and issues

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/fetch_buf.sv | 61 ++++++
 rtl/fetch_stage.sv | 104 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants used by the fetch front end.
package cpu_pkg;

   localparam int XLEN    = 64;
   localparam int INSTR_W = 32;

   typedef logic [XLEN-1:0]    addr_t;
   typedef logic [INSTR_W-1:0] instr_t;

   localparam addr_t INSTR_BYTES = addr_t'(4);

   typedef enum logic {
      BOOT,
      RUN
   } fetch_state_t;

   typedef struct packed {
      instr_t instr;
      addr_t  pc;
   } buf_entry_t;

   function automatic addr_t word_align(addr_t a);
      return a & ~(INSTR_BYTES - addr_t'(1));
   endfunction

endpackage

// File: rtl/fetch_buf.sv
// Small FIFO of fetched {instr, pc} pairs; DEPTH must be a power of two (2 or 4).
module fetch_buf
   import cpu_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  buf_entry_t       push_entry,
   input  logic             pop,
   output buf_entry_t       head_entry,
   output logic [CNT_W-1:0] count
);

   buf_entry_t       mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop, full;

   // Flush dominates; a push at full is only accepted alongside a pop.
   always_comb begin
      full     = (count_q == CNT_W'(DEPTH));
      do_pop   = pop & ~flush & (count_q != '0);
      do_push  = push & ~flush & (~full | do_pop);
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (do_push) mem_q[wr_ptr_q] <= push_entry;
      end
   end

   assign head_entry = mem_q[rd_ptr_q];
   assign count      = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues imem reads, buffers returned
// words and hands them to decode; redirects squash everything still in flight.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter addr_t RESET_PC  = 64'h0,
   parameter int    BUF_DEPTH = 2
) (
   input  logic   clk,
   input  logic   reset,
   output logic   imem_req,
   output addr_t  imem_addr,
   input  instr_t imem_rdata,
   input  logic   redirect,
   input  addr_t  redirect_pc,
   input  logic   id_ready,
   output logic   id_valid,
   output instr_t id_instr,
   output addr_t  id_pc,
   output addr_t  id_pc4
);

   localparam int CNT_W = $clog2(BUF_DEPTH + 1);
   localparam int OCC_W = CNT_W + 1;
   localparam logic [OCC_W-1:0] DEPTH_O = OCC_W'(BUF_DEPTH);

   fetch_state_t     state_q, state_d;
   addr_t            pc_q, pc_d;
   logic             epoch_q, epoch_d;
   logic             inflight_q, inflight_d;
   logic             infl_epoch_q, infl_epoch_d;
   addr_t            infl_pc_q, infl_pc_d;

   logic [CNT_W-1:0] buf_count;
   buf_entry_t       head_entry;
   buf_entry_t       push_entry;
   logic             pop, issue, rsp_live, push;
   logic [OCC_W-1:0] occupancy;

   // A response only counts toward occupancy if it was issued in the current epoch.
   always_comb begin
      pop        = id_valid & id_ready;
      rsp_live   = inflight_q & (infl_epoch_q == epoch_q);
      occupancy  = {1'b0, buf_count} + OCC_W'(rsp_live) - OCC_W'(pop);
      issue      = (state_q == RUN) && (occupancy < DEPTH_O);
      push       = rsp_live & ~redirect;
      push_entry = '{instr: imem_rdata, pc: infl_pc_q};

      imem_req     = issue;
      imem_addr    = pc_q;
      state_d      = state_q;
      pc_d         = pc_q;
      epoch_d      = epoch_q;
      inflight_d   = issue;
      infl_epoch_d = epoch_q;
      infl_pc_d    = infl_pc_q;

      if (state_q == BOOT) state_d = RUN;
      if (issue) begin
         infl_pc_d = pc_q;
         pc_d      = pc_q + INSTR_BYTES;
      end
      if (redirect) begin
         pc_d    = word_align(redirect_pc);
         epoch_d = ~epoch_q;
         state_d = RUN;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= BOOT;
         pc_q         <= RESET_PC;
         epoch_q      <= 1'b0;
         inflight_q   <= 1'b0;
         infl_epoch_q <= 1'b0;
         infl_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         epoch_q      <= epoch_d;
         inflight_q   <= inflight_d;
         infl_epoch_q <= infl_epoch_d;
         infl_pc_q    <= infl_pc_d;
      end
   end

   fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
      .clk        (clk),
      .reset      (reset),
      .flush      (redirect),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head_entry (head_entry),
      .count      (buf_count)
   );

   assign id_valid = (buf_count != '0);
   assign id_instr = id_valid ? head_entry.instr : '0;
   assign id_pc    = id_valid ? head_entry.pc : '0;
   assign id_pc4   = id_valid ? head_entry.pc + INSTR_BYTES : '0;

endmodule
